fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch byte address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, meaning the byte increment per sequential fetch.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  meaning asynchronous, active-low reset; assertion clears state immediately, deassertion takes effect at the next rising edge of clk.
REQ-005 SHALL have port imem_addr  out  32  meaning the word address to imem, equal to pc[31:2].
REQ-006 SHALL have port imem_rw  out  1  meaning the imem read/write select; held at 1 (read) at all times.
REQ-007 SHALL have port imem_data_in  out  32  meaning the imem write data; tied to 0.
REQ-008 SHALL have port imem_instr  in  32  meaning the imem read data, valid one cycle after imem_addr.
REQ-009 SHALL have port redirect_valid  in  1  meaning a branch/jump target is presented this cycle.
REQ-010 SHALL have port redirect_pc  in  32  meaning the target byte address.
REQ-011 SHALL have port if_valid  out  1  meaning if_pc/if_instr hold a fetched instruction.
REQ-012 SHALL have port if_ready  in  1  meaning decode accepts the instruction this cycle.
REQ-013 SHALL have port if_pc  out  32  meaning the byte address of if_instr.
REQ-014 SHALL have port if_instr  out  32  meaning the fetched instruction word.

Function
REQ-015 SHALL implement states IDLE, RUN, STALL: IDLE for one cycle after reset release, then RUN.
REQ-016 SHALL in RUN present pc on imem_addr and advance pc by PC_STEP each cycle while the buffer has a free entry.
REQ-017 SHALL tag each issued request with its pc and capture imem_instr with that pc one cycle later.
REQ-018 SHALL hold captured words in a 2-entry FIFO (skid buffer) and drive if_valid/if_pc/if_instr from its head.
REQ-019 SHALL pop the head on if_valid && if_ready; a transfer never occurs with if_valid low.
REQ-020 SHALL enter STALL (pc frozen, no new request issued) when the FIFO count plus requests in flight equals 2; return to RUN when an entry frees.
REQ-021 SHALL keep if_pc/if_instr stable while if_valid && !if_ready.
REQ-022 SHALL on redirect_valid in any state except IDLE: flush the FIFO, discard the in-flight request, set pc to redirect_pc and issue it the next cycle; if_valid is low the cycle after the redirect.
REQ-023 SHALL give redirect_valid priority over a simultaneous pop and stall; the popped word is still considered accepted.
REQ-024 SHALL wrap pc from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
REQ-025 SHALL ignore redirect_pc[1:0] (force to 0) unless FETCH_MISALIGN_EN is defined.
REQ-026 SHALL give a first-instruction latency of 3 cycles from reset release to if_valid (IDLE, issue, capture).

Reset
REQ-027 SHALL on reset set pc=RESET_PC, state=IDLE, FIFO empty, in-flight cleared, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), imem_addr=RESET_PC[31:2].
REQ-028 SHALL abandon any in-flight request when reset is asserted mid-operation, producing no output for it after release.

Configuration
REQ-029 SHALL, when FETCH_MISALIGN_EN is defined, add output if_misalign (1 bit): a redirect with redirect_pc[1:0]!=0 flushes, presents if_valid=1, if_misalign=1, if_pc=redirect_pc, if_instr=NOP, and issues no fetch until the next redirect.
REQ-030 SHALL, when FETCH_MISALIGN_EN is undefined, omit if_misalign and apply REQ-025.

Structure
REQ-031 SHALL take XLEN (32), NOP_INSTR (32'h0000_0013) and the fetch state enumeration from shared package riscv_pkg.
REQ-032 SHALL implement the 2-entry FIFO as sub-module fetch_skid_buf (push, pop, flush, count, head data).

Verification
REQ-033 SHALL test: reset release, if_ready=1 -> if_valid at cycle 3, if_pc sequence 0,4,8,12 with matching imem words.
REQ-034 SHALL test: if_ready=0 for 5 cycles after first valid -> if_pc held at 0, imem_addr frozen, no word lost or duplicated on release.
REQ-035 SHALL test: redirect_valid with redirect_pc=32'h100 while FIFO full -> next valid if_pc=32'h100, no stale 4/8 delivered.
REQ-036 SHALL test: RESET_PC=32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 SHALL test: reset asserted during stall -> if_valid=0 immediately, first fetch after release at RESET_PC.
REQ-038 SHALL test (FETCH_MISALIGN_EN): redirect_pc=32'h102 -> if_misalign=1, if_pc=32'h102, if_instr=NOP, imem_addr static.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: data width, NOP encoding, fetch FSM states.
// Latency: n/a (types only). Backpressure: n/a.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, STALL} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding fetched {pc, instr} pairs; head presented combinationally.
// Latency: push visible at head the cycle after. Backpressure: caller never pushes when full without popping.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head_dat
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Payload storage needs no reset: count gates its visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues pc to imem, tags and buffers returned words in a 2-deep skid buffer.
// Latency: 3 cycles reset-release to first if_valid; 3 cycles redirect to target word. Backpressure: stalls pc when buffer+in-flight reach 2.
// Optional FETCH_MISALIGN_EN adds if_misalign reporting of misaligned redirects.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_rw,
  output logic [XLEN-1:0] imem_data_in,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
`ifdef FETCH_MISALIGN_EN
  ,
  output logic            if_misalign
`endif
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            inflight_vld, inflight_nxt;
  logic [XLEN-1:0] inflight_pc, inflight_pc_nxt;
  logic            redirect, redir_bad, issue, push, pop, fifo_vld, mis_hold;
  logic [1:0]      fifo_count, occ_nxt;
  logic [XLEN-1:0] redir_tgt;
  fetch_entry_t    head;

  assign redirect  = redirect_valid && (state != IDLE);
  assign redir_tgt = redirect_pc & ~32'h3;
  assign fifo_vld  = (fifo_count != 2'd0);
  assign pop       = fifo_vld && if_ready && !mis_hold;
  assign push      = inflight_vld && !redirect;
  // STALL only lets a new request out when a pop frees an entry this cycle.
  assign issue     = !redirect && !mis_hold &&
                     ((state == RUN) || ((state == STALL) && pop));
  assign occ_nxt   = fifo_count + {1'b0, push} - {1'b0, pop} + {1'b0, inflight_nxt};

`ifdef FETCH_MISALIGN_EN
  logic [XLEN-1:0] mis_pc;
  assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_hold <= 1'b0;
      mis_pc   <= '0;
    end else if (redirect) begin
      mis_hold <= redir_bad;
      mis_pc   <= redirect_pc;
    end
  end

  assign if_misalign = mis_hold;
  assign if_valid    = mis_hold || fifo_vld;
  assign if_pc       = mis_hold ? mis_pc : (fifo_vld ? head.pc : '0);
  assign if_instr    = (!mis_hold && fifo_vld) ? head.instr : NOP_INSTR;
`else
  assign redir_bad = 1'b0;
  assign mis_hold  = 1'b0;
  assign if_valid  = fifo_vld;
  assign if_pc     = fifo_vld ? head.pc : '0;
  assign if_instr  = fifo_vld ? head.instr : NOP_INSTR;
`endif

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    inflight_nxt    = 1'b0;
    inflight_pc_nxt = inflight_pc;
    case (state)
      IDLE: state_nxt = RUN;
      default: begin
        if (redirect) begin
          // A misaligned target parks the unit with pc untouched.
          pc_nxt    = redir_bad ? pc : redir_tgt;
          state_nxt = RUN;
        end else begin
          if (issue) begin
            pc_nxt          = pc + XLEN'(PC_STEP);
            inflight_nxt    = 1'b1;
            inflight_pc_nxt = pc;
          end
          state_nxt = (occ_nxt == 2'd2) ? STALL : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      inflight_vld <= 1'b0;
      inflight_pc  <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      inflight_vld <= inflight_nxt;
      inflight_pc  <= inflight_pc_nxt;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat ({inflight_pc, imem_instr}),
    .pop      (pop),
    .flush    (redirect),
    .count    (fifo_count),
    .head_dat (head)
  );

  assign imem_addr    = {2'b00, pc[XLEN-1:2]};
  assign imem_rw      = 1'b1;
  assign imem_data_in = '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency, backpressure, redirect, pc wrap, mid-run reset.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] imem_addr, imem_data_in, imem_instr, redirect_pc, if_pc, if_instr;
  logic        imem_rw, redirect_valid, if_valid, if_ready;
  logic [31:0] b_imem_addr, b_imem_data_in, b_imem_instr, b_if_pc, b_if_instr;
  logic        b_imem_rw, b_if_valid;
  logic        b_ready = 1'b1;
  logic        b_redirect = 1'b0;
  logic [31:0] b_redirect_pc = 32'h0;
`ifdef FETCH_MISALIGN_EN
  logic        if_misalign, b_if_misalign;
`endif

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk(clk), .reset(rst_n),
    .imem_addr(imem_addr), .imem_rw(imem_rw), .imem_data_in(imem_data_in),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
`ifdef FETCH_MISALIGN_EN
    , .if_misalign(if_misalign)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(rst_n),
    .imem_addr(b_imem_addr), .imem_rw(b_imem_rw), .imem_data_in(b_imem_data_in),
    .imem_instr(b_imem_instr),
    .redirect_valid(b_redirect), .redirect_pc(b_redirect_pc),
    .if_valid(b_if_valid), .if_ready(b_ready), .if_pc(b_if_pc), .if_instr(b_if_instr)
`ifdef FETCH_MISALIGN_EN
    , .if_misalign(b_if_misalign)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] word_addr);
    return 32'h5A00_0000 ^ word_addr;
  endfunction

  function automatic logic [31:0] pc_word(input logic [31:0] p);
    return mem_word({2'b00, p[31:2]});
  endfunction

  // Synchronous-read instruction memories.
  always @(posedge clk) begin
    imem_instr   <= mem_word(imem_addr);
    b_imem_instr <= mem_word(b_imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0;
    if_ready = rdy;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Checks every accepted word against a sequential pc stream starting at start_pc.
  task automatic collect(input logic [31:0] start_pc, input int n, input string tag);
    logic [31:0] exp_pc;
    int got;
    exp_pc = start_pc;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (if_valid && if_ready) begin
        check({tag, " pc"}, if_pc, exp_pc);
        check({tag, " instr"}, if_instr, pc_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        got++;
        if (got == n) break;
      end
      @(negedge clk);
    end
    if (got != n) check({tag, " count"}, 32'(got), 32'(n));
  endtask

  initial begin
    rst_n = 1'b0;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    check("rst if_valid", {31'b0, if_valid}, 32'h0);
    check("rst if_pc", if_pc, 32'h0);
    check("rst if_instr", if_instr, 32'h0000_0013);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst imem_rw", {31'b0, imem_rw}, 32'h1);
    check("rst imem_data_in", imem_data_in, 32'h0);
    check("rst wrap imem_addr", b_imem_addr, 32'h3FFF_FFFE);
    rst_n = 1'b1;

    // First-word latency and sequential stream on both instances.
    @(negedge clk);
    check("lat c1 valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    check("lat c2 valid", {31'b0, if_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("seq valid", {31'b0, if_valid}, 32'h1);
      check("seq pc", if_pc, 32'(4 * k));
      check("seq instr", if_instr, pc_word(32'(4 * k)));
      check("wrap valid", {31'b0, b_if_valid}, 32'h1);
      check("wrap pc", b_if_pc, 32'hFFFF_FFF8 + 32'(4 * k));
      check("wrap instr", b_if_instr, pc_word(32'hFFFF_FFF8 + 32'(4 * k)));
    end

    // Decode backpressure right from the first valid word.
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold valid", {31'b0, if_valid}, 32'h1);
      check("hold pc", if_pc, 32'h0);
      check("hold instr", if_instr, pc_word(32'h0));
      check("hold imem_addr", imem_addr, 32'h2);
    end
    if_ready = 1'b1;
    collect(32'h0, 6, "release");

    // Redirect while the buffer is full, with a simultaneous pop.
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    check("full head pc", if_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    if_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir flush valid", {31'b0, if_valid}, 32'h0);
    check("redir imem_addr", imem_addr, 32'h40);
    collect(32'h100, 3, "redir");

`ifndef FETCH_MISALIGN_EN
    // Target low bits are dropped.
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    collect(32'h200, 2, "lsb drop");
`endif

    // Asynchronous reset during a stall.
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    check("pre-rst stall valid", {31'b0, if_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async rst valid", {31'b0, if_valid}, 32'h0);
    check("async rst pc", if_pc, 32'h0);
    check("async rst instr", if_instr, 32'h0000_0013);
    check("async rst imem_addr", imem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    if_ready = 1'b1;
    @(negedge clk);
    check("post-rst c1 valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    check("post-rst c2 valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    collect(32'h0, 3, "post-rst");

`ifdef FETCH_MISALIGN_EN
    // Misaligned redirect parks the unit until the next redirect.
    do_reset(1'b1);
    collect(32'h0, 2, "mis pre");
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("mis flag", {31'b0, if_misalign}, 32'h1);
      check("mis valid", {31'b0, if_valid}, 32'h1);
      check("mis pc", if_pc, 32'h102);
      check("mis instr", if_instr, 32'h0000_0013);
      check("mis imem_addr", imem_addr, 32'h3);
      @(negedge clk);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("mis clear", {31'b0, if_misalign}, 32'h0);
    collect(32'h10, 2, "mis recover");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
